// File: rtl/dcache_pkg.sv
// Shared types for the data cache.
//   DCACHE_SETS / DCACHE_IDX_W / DCACHE_TAG_W : default geometry (16 direct-mapped frames)
//   CNT_ADDR       : word address that receives the final hit count after a flush
//   dcachef_t      : byte address split into {tag, idx, bytoff}
//   dcache_frame_t : one cache frame {valid, dirty, tag, data}
//   dcache_state_t : controller states
package dcache_pkg;

  localparam int DCACHE_SETS  = 16;
  localparam int DCACHE_IDX_W = $clog2(DCACHE_SETS);
  localparam int DCACHE_TAG_W = 30 - DCACHE_IDX_W;

  localparam logic [31:0] CNT_ADDR = 32'h0000_3100;

  typedef struct packed {
    logic [DCACHE_TAG_W-1:0] tag;
    logic [DCACHE_IDX_W-1:0] idx;
    logic [1:0]              bytoff;
  } dcachef_t;

  typedef struct packed {
    logic                    valid;
    logic                    dirty;
    logic [DCACHE_TAG_W-1:0] tag;
    logic [31:0]             data;
  } dcache_frame_t;

  typedef enum logic [2:0] {
    IDLE,
    WB,
    FETCH,
    FLUSH,
    CNT,
    DONE
  } dcache_state_t;

endpackage

// File: rtl/dcache_if.sv
// Bus interfaces around the data cache.
//   dcache_dp_if  : datapath MEM stage <-> cache
//     master (datapath): drives halt, dmemREN, dmemWEN, dmemaddr, dmemstore
//     slave  (cache)   : drives dhit, dmemload, flushed
//   dcache_mem_if : cache <-> memory controller
//     master (cache)   : drives dREN, dWEN, daddr, dstore
//     slave  (memory)  : drives dwait, dload
interface dcache_dp_if;
  logic        halt;
  logic        dmemREN;
  logic        dmemWEN;
  logic [31:0] dmemaddr;
  logic [31:0] dmemstore;
  logic        dhit;
  logic [31:0] dmemload;
  logic        flushed;

  modport master (
    output halt, dmemREN, dmemWEN, dmemaddr, dmemstore,
    input  dhit, dmemload, flushed
  );

  modport slave (
    input  halt, dmemREN, dmemWEN, dmemaddr, dmemstore,
    output dhit, dmemload, flushed
  );
endinterface

interface dcache_mem_if;
  logic        dREN;
  logic        dWEN;
  logic [31:0] daddr;
  logic [31:0] dstore;
  logic        dwait;
  logic [31:0] dload;

  modport master (
    output dREN, dWEN, daddr, dstore,
    input  dwait, dload
  );

  modport slave (
    input  dREN, dWEN, daddr, dstore,
    output dwait, dload
  );
endinterface

// File: rtl/dcache.sv
// Direct-mapped, write-back, write-allocate data cache with one-word blocks.
// Services datapath loads/stores in one cycle on a hit; misses write back a
// dirty victim and then fetch the word. On halt every dirty frame is written
// back, the hit count is stored to CNT_ADDR, and flushed is raised for good.
// Ports:
//   CLK  : clock, rising edge
//   nRST : asynchronous active-low reset
//   dp   : datapath side (dcache_dp_if.slave)
//   mem  : memory controller side (dcache_mem_if.master)
module dcache #(
  parameter int          SETS     = dcache_pkg::DCACHE_SETS,
  parameter logic [31:0] CNT_ADDR = dcache_pkg::CNT_ADDR
) (
  input  logic          CLK,
  input  logic          nRST,
  dcache_dp_if.slave    dp,
  dcache_mem_if.master  mem
);
  import dcache_pkg::*;

  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = 30 - IDX_W;

  // Address split at this instance's geometry.
  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic [IDX_W-1:0] idx;
    logic [1:0]       bytoff;
  } addr_t;

  // Frame array, one field per array so only valid/dirty carry a reset.
  logic [SETS-1:0]  valid;
  logic [SETS-1:0]  dirty;
  logic [TAG_W-1:0] tag_mem  [SETS];
  logic [31:0]      data_mem [SETS];

  dcache_state_t    state, state_next;
  logic [IDX_W-1:0] fidx, fidx_next;
  logic [31:0]      hit_count;
  logic             retry;

  // The missing address is captured when the miss is detected, so the
  // memory-side address stays constant even if the datapath drops or changes
  // its request while the miss is outstanding.
  logic [TAG_W-1:0] miss_tag;
  logic [IDX_W-1:0] miss_idx;

  addr_t            req;
  logic             req_valid;
  logic             req_write;
  logic             req_hit;

  // Frame-update controls produced by the next-state logic.
  logic             hit_en;
  logic             fill_en;
  logic             clean_en;
  logic [IDX_W-1:0] clean_idx;
  logic             miss_latch;
  logic             flush_adv;

  logic             unused_bytoff;

  assign req           = addr_t'(dp.dmemaddr);
  assign req_valid     = dp.dmemREN | dp.dmemWEN;
  assign req_write     = dp.dmemWEN;  // a write wins when both strobes are set
  assign req_hit       = valid[req.idx] && (tag_mem[req.idx] == req.tag);
  assign unused_bytoff = ^req.bytoff;

  // NOTE: every signal written here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_next   = state;
    fidx_next    = fidx;
    hit_en       = 1'b0;
    fill_en      = 1'b0;
    clean_en     = 1'b0;
    clean_idx    = miss_idx;
    miss_latch   = 1'b0;
    flush_adv    = 1'b0;
    dp.dhit      = 1'b0;
    dp.dmemload  = '0;
    dp.flushed   = 1'b0;
    mem.dREN     = 1'b0;
    mem.dWEN     = 1'b0;
    mem.daddr    = '0;
    mem.dstore   = '0;

    unique case (state)
      IDLE: begin
        if (dp.halt) begin
          state_next = FLUSH;
          fidx_next  = '0;
        end else if (req_valid) begin
          if (req_hit) begin
            dp.dhit = 1'b1;
            hit_en  = 1'b1;
            if (!req_write) dp.dmemload = data_mem[req.idx];
          end else begin
            miss_latch = 1'b1;
            state_next = (valid[req.idx] && dirty[req.idx]) ? WB : FETCH;
          end
        end
      end

      WB: begin
        mem.dWEN   = 1'b1;
        mem.daddr  = {tag_mem[miss_idx], miss_idx, 2'b00};
        mem.dstore = data_mem[miss_idx];
        if (!mem.dwait) begin
          clean_en   = 1'b1;
          state_next = FETCH;
        end
      end

      FETCH: begin
        mem.dREN  = 1'b1;
        mem.daddr = {miss_tag, miss_idx, 2'b00};
        if (!mem.dwait) begin
          fill_en    = 1'b1;
          state_next = IDLE;
        end
      end

      FLUSH: begin
        if (valid[fidx] && dirty[fidx]) begin
          mem.dWEN   = 1'b1;
          mem.daddr  = {tag_mem[fidx], fidx, 2'b00};
          mem.dstore = data_mem[fidx];
          if (!mem.dwait) begin
            clean_en  = 1'b1;
            clean_idx = fidx;
            flush_adv = 1'b1;
          end
        end else begin
          flush_adv = 1'b1;  // clean or invalid frame: skip without a bus cycle
        end
        if (flush_adv) begin
          if (fidx == IDX_W'(SETS - 1)) state_next = CNT;
          else                          fidx_next  = fidx + 1'b1;
        end
      end

      CNT: begin
        mem.dWEN   = 1'b1;
        mem.daddr  = CNT_ADDR;
        mem.dstore = hit_count;
        if (!mem.dwait) state_next = DONE;
      end

      DONE: begin
        dp.flushed = 1'b1;
      end

      default: state_next = IDLE;
    endcase
  end

  // NOTE: clocked state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state     <= IDLE;
      fidx      <= '0;
      hit_count <= '0;
      retry     <= 1'b0;
      miss_tag  <= '0;
      miss_idx  <= '0;
    end else begin
      state <= state_next;
      fidx  <= fidx_next;
      // The hit that completes a miss replays the original request; only
      // first-time hits are counted.
      if (hit_en) begin
        retry <= 1'b0;
        if (!retry) hit_count <= hit_count + 32'd1;
      end
      if (fill_en) retry <= 1'b1;
      if (miss_latch) begin
        miss_tag <= req.tag;
        miss_idx <= req.idx;
      end
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      valid <= '0;
      dirty <= '0;
    end else begin
      if (hit_en && req_write) dirty[req.idx] <= 1'b1;
      if (clean_en)            dirty[clean_idx] <= 1'b0;
      if (fill_en) begin
        valid[miss_idx] <= 1'b1;
        dirty[miss_idx] <= 1'b0;
      end
    end
  end

  // NOTE: tag and data storage is deliberately left without reset; a frame's
  // contents are never used while its valid bit is clear.
  always_ff @(posedge CLK) begin
    if (hit_en && req_write) begin
      data_mem[req.idx] <= dp.dmemstore;
    end else if (fill_en) begin
      data_mem[miss_idx] <= mem.dload;
      tag_mem[miss_idx]  <= miss_tag;
    end
  end

endmodule

// File: tb/tb_dcache.sv
`timescale 1ns/1ps
// Directed bench for dcache: cold read miss, write allocate and hits,
// dirty-victim writeback, combined REN/WEN, halt flush with hit count,
// and reset in the middle of a fetch.
module tb_dcache;

  logic CLK = 1'b0;
  logic nRST;
  always #5 CLK = ~CLK;

  dcache_dp_if  dp ();
  dcache_mem_if mb ();

  dcache dut (
    .CLK  (CLK),
    .nRST (nRST),
    .dp   (dp.slave),
    .mem  (mb.master)
  );

  int n_assert = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // ---------------- memory controller model ----------------
  logic [31:0] mem [logic [31:0]];
  int          wait_cnt   = 0;
  int          mem_lat    = 2;   // wait cycles before the completing cycle
  int          ren_cycles = 0;
  int          wen_cycles = 0;
  logic [31:0] wr_addr_q [$];
  logic [31:0] wr_data_q [$];

  initial begin
    mb.dwait = 1'b1;
    mb.dload = '0;
  end

  always @(negedge CLK) begin
    if (mb.dREN || mb.dWEN) begin
      if (mb.dREN) ren_cycles++;
      if (mb.dWEN) wen_cycles++;
      check("strobes_exclusive", {31'b0, mb.dREN & mb.dWEN}, 32'd0);
      if (wait_cnt < mem_lat) begin
        mb.dwait = 1'b1;
        wait_cnt++;
      end else begin
        mb.dwait = 1'b0;
        wait_cnt = 0;
        if (mb.dWEN) begin
          mem[mb.daddr] = mb.dstore;
          wr_addr_q.push_back(mb.daddr);
          wr_data_q.push_back(mb.dstore);
        end else begin
          mb.dload = mem.exists(mb.daddr) ? mem[mb.daddr] : 32'hBAD0_0000;
        end
      end
    end else begin
      mb.dwait = 1'b1;
      wait_cnt = 0;
    end
  end

  function automatic logic [31:0] wr_addr_at(input int i);
    return (i < wr_addr_q.size()) ? wr_addr_q[i] : 32'hFFFF_FFFF;
  endfunction

  function automatic logic [31:0] wr_data_at(input int i);
    return (i < wr_data_q.size()) ? wr_data_q[i] : 32'hFFFF_FFFF;
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(negedge CLK);
    #1;
  endtask

  task automatic drive(input logic ren, input logic wen, input logic [31:0] addr,
                       input logic [31:0] data);
    dp.dmemREN   = ren;
    dp.dmemWEN   = wen;
    dp.dmemaddr  = addr;
    dp.dmemstore = data;
    #1;
  endtask

  task automatic wait_hit(input string tag, input int max);
    int n = 0;
    while (!dp.dhit && n < max) begin
      step();
      n++;
    end
    check({tag, "_hit_seen"}, {31'b0, dp.dhit}, 32'd1);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_dhit"},     {31'b0, dp.dhit},    32'd0);
    check({tag, "_dmemload"}, dp.dmemload,         32'd0);
    check({tag, "_flushed"},  {31'b0, dp.flushed}, 32'd0);
    check({tag, "_dREN"},     {31'b0, mb.dREN},    32'd0);
    check({tag, "_dWEN"},     {31'b0, mb.dWEN},    32'd0);
    check({tag, "_daddr"},    mb.daddr,            32'd0);
    check({tag, "_dstore"},   mb.dstore,           32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  // ---------------- directed sequence ----------------
  initial begin
    int n;
    mem[32'h40]  = 32'hA5A5_0040;
    mem[32'h44]  = 32'hA5A5_0044;
    mem[32'h84]  = 32'hA5A5_0084;
    mem[32'hC8]  = 32'hA5A5_00C8;
    mem[32'h100] = 32'hA5A5_0100;

    nRST = 1'b0;
    dp.halt = 1'b0;
    drive(1'b0, 1'b0, 32'h0, 32'h0);
    #1;
    check_all_zero("reset");
    step();
    nRST = 1'b1;

    // 1: cold read miss, three dREN cycles, then the replayed hit
    ren_cycles = 0;
    drive(1'b1, 1'b0, 32'h40, 32'h0);
    check("t1_miss_dhit", {31'b0, dp.dhit}, 32'd0);
    check("t1_idle_dREN", {31'b0, mb.dREN}, 32'd0);
    step();
    check("t1_fetch_dREN",  {31'b0, mb.dREN}, 32'd1);
    check("t1_fetch_dWEN",  {31'b0, mb.dWEN}, 32'd0);
    check("t1_fetch_daddr", mb.daddr, 32'h40);
    wait_hit("t1", 20);
    check("t1_ren_cycles", ren_cycles, 32'd3);
    check("t1_load", dp.dmemload, 32'hA5A5_0040);
    step();

    // 2: write miss allocates 0x44; later hits need no memory traffic
    drive(1'b0, 1'b1, 32'h44, 32'hDEAD_BEEF);
    check("t2_wmiss_dhit", {31'b0, dp.dhit}, 32'd0);
    wait_hit("t2_fill", 20);
    check("t2_wr_load", dp.dmemload, 32'd0);
    step();
    ren_cycles = 0;
    wen_cycles = 0;
    drive(1'b0, 1'b1, 32'h40, 32'h1234_5678);   // counted hit 1
    check("t2_wr_hit", {31'b0, dp.dhit}, 32'd1);
    step();
    drive(1'b1, 1'b0, 32'h44, 32'h0);            // counted hit 2
    check("t2_rd_hit",  {31'b0, dp.dhit}, 32'd1);
    check("t2_rd_data", dp.dmemload, 32'hDEAD_BEEF);
    step();
    check("t2_no_mem", ren_cycles + wen_cycles, 32'd0);

    // 3: conflict on index 1 evicts dirty 0x44 before fetching 0x84
    ren_cycles = 0;
    wen_cycles = 0;
    drive(1'b1, 1'b0, 32'h84, 32'h0);
    check("t3_miss_dhit", {31'b0, dp.dhit}, 32'd0);
    step();
    check("t3_wb_dWEN",   {31'b0, mb.dWEN}, 32'd1);
    check("t3_wb_dREN",   {31'b0, mb.dREN}, 32'd0);
    check("t3_wb_daddr",  mb.daddr,  32'h44);
    check("t3_wb_dstore", mb.dstore, 32'hDEAD_BEEF);
    n = 0;
    while (!mb.dREN && n < 20) begin
      step();
      n++;
    end
    check("t3_fetch_dREN",  {31'b0, mb.dREN}, 32'd1);
    check("t3_fetch_daddr", mb.daddr, 32'h84);
    check("t3_wb_cycles",   wen_cycles, 32'd3);
    check("t3_mem44",       mem[32'h44], 32'hDEAD_BEEF);
    wait_hit("t3", 20);
    check("t3_load", dp.dmemload, 32'hA5A5_0084);
    step();

    // 5: both strobes on a miss behave as a write
    drive(1'b1, 1'b1, 32'hC8, 32'hCAFE_F00D);
    check("t5_miss_dhit", {31'b0, dp.dhit}, 32'd0);
    step();
    check("t5_fetch_dREN",  {31'b0, mb.dREN}, 32'd1);
    check("t5_fetch_dWEN",  {31'b0, mb.dWEN}, 32'd0);
    check("t5_fetch_daddr", mb.daddr, 32'hC8);
    wait_hit("t5", 20);
    check("t5_wr_load", dp.dmemload, 32'd0);
    step();
    drive(1'b1, 1'b0, 32'hC8, 32'h0);            // counted hit 3
    check("t5_rd_data", dp.dmemload, 32'hCAFE_F00D);
    step();

    // 4: halt flushes frames 0 and 2, then stores the hit count
    wr_addr_q.delete();
    wr_data_q.delete();
    ren_cycles = 0;
    dp.halt = 1'b1;
    drive(1'b0, 1'b0, 32'h0, 32'h0);
    n = 0;
    while (!dp.flushed && n < 200) begin
      step();
      n++;
    end
    check("t4_flushed",  {31'b0, dp.flushed}, 32'd1);
    check("t4_nwrites",  wr_addr_q.size(), 32'd3);
    check("t4_w0_addr",  wr_addr_at(0), 32'h40);
    check("t4_w0_data",  wr_data_at(0), 32'h1234_5678);
    check("t4_w1_addr",  wr_addr_at(1), 32'hC8);
    check("t4_w1_data",  wr_data_at(1), 32'hCAFE_F00D);
    check("t4_w2_addr",  wr_addr_at(2), 32'h3100);
    check("t4_w2_data",  wr_data_at(2), 32'd3);
    check("t4_no_reads", ren_cycles, 32'd0);
    drive(1'b1, 1'b0, 32'h84, 32'h0);
    check("t4_done_dhit", {31'b0, dp.dhit}, 32'd0);
    step();
    step();
    step();
    check("t4_flushed_held", {31'b0, dp.flushed}, 32'd1);
    check("t4_done_dREN",    {31'b0, mb.dREN}, 32'd0);
    check("t4_done_dWEN",    {31'b0, mb.dWEN}, 32'd0);
    check("t4_done_dhit2",   {31'b0, dp.dhit}, 32'd0);

    // 6: reset in the middle of a fetch abandons it
    dp.halt = 1'b0;
    drive(1'b0, 1'b0, 32'h0, 32'h0);
    nRST = 1'b0;
    #1;
    check("t6_rst_flushed", {31'b0, dp.flushed}, 32'd0);
    step();
    nRST = 1'b1;
    drive(1'b1, 1'b0, 32'h100, 32'h0);
    step();
    check("t6_fetch_dREN",  {31'b0, mb.dREN}, 32'd1);
    check("t6_fetch_daddr", mb.daddr, 32'h100);
    nRST = 1'b0;
    #1;
    check_all_zero("t6_midrst");
    step();
    nRST = 1'b1;
    #1;
    check("t6_rerd_miss", {31'b0, dp.dhit}, 32'd0);
    step();
    check("t6_refetch_dREN",  {31'b0, mb.dREN}, 32'd1);
    check("t6_refetch_daddr", mb.daddr, 32'h100);
    wait_hit("t6", 20);
    check("t6_load", dp.dmemload, 32'hA5A5_0100);
    step();
    drive(1'b0, 1'b0, 32'h0, 32'h0);
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
